fp32_minmax_calib_ctrl: RTL and testbench

// Quantisation-calibration sequencer around fp32_maxmin_finder_pipe.
// - Accepts a job of cfg_len fp32 elements, streamed LANES per beat.
// - Feeds each beat through one finder instance and folds its results into running max/min registers.
// - Reports the tensor-wide max/min once per job; downstream logic derives the scale/zero-point from them.

---
 rtl/fp32_minmax_calib_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_fp32_minmax_calib_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_minmax_calib_ctrl.sv
// Quantisation-calibration sequencer: streams a job of fp32 beats through a
// max/min finder tree and folds each beat into tensor-wide max/min accumulators.

module fp32_maxmin_unit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] max_o,
  output logic [31:0] min_o
);
  logic a_nan, b_nan, a_lt_b;

  // A single NaN yields the other operand; -0 orders below +0.
  always_comb begin
    a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    if (a_i[31] != b_i[31])
      a_lt_b = a_i[31];
    else if (a_i[31])
      a_lt_b = a_i[30:0] > b_i[30:0];
    else
      a_lt_b = a_i[30:0] < b_i[30:0];
    max_o = a_lt_b ? b_i : a_i;
    min_o = a_lt_b ? a_i : b_i;
    if (a_nan && b_nan) begin
      max_o = 32'h7FC0_0000;
      min_o = 32'h7FC0_0000;
    end else if (a_nan) begin
      max_o = b_i;
      min_o = b_i;
    end else if (b_nan) begin
      max_o = a_i;
      min_o = a_i;
    end
  end
endmodule

module fp32_maxmin_finder_pipe #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned PIPELINE   = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [NUM_INPUTS*32-1:0] in_data,
  output logic                    out_valid,
  output logic [31:0]             out_max,
  output logic [31:0]             out_min
);
  localparam int unsigned LV = $clog2(NUM_INPUTS);
  localparam int unsigned P  = 1 << LV;

  logic [P-1:0][31:0] leaf;

  // Tree is padded to a power of two with lane 0, which is neutral for max and min.
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < NUM_INPUTS) begin : g_real
      assign leaf[i] = in_data[i*32 +: 32];
    end else begin : g_pad
      assign leaf[i] = in_data[31:0];
    end
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int unsigned W = P >> (l + 1);
    logic [W-1:0][31:0] cmx, cmn, rmx, rmn;
    logic cv, rv;

    if (l == 0) begin : g_v0
      assign cv = in_valid;
    end else begin : g_vn
      assign cv = g_lvl[l-1].rv;
    end

    for (genvar n = 0; n < W; n++) begin : g_node
      logic [31:0] amx, bmx, amn, bmn, lo_unused, hi_unused;
      if (l == 0) begin : g_first
        assign amx = leaf[2*n];
        assign bmx = leaf[2*n+1];
        assign amn = leaf[2*n];
        assign bmn = leaf[2*n+1];
      end else begin : g_inner
        assign amx = g_lvl[l-1].rmx[2*n];
        assign bmx = g_lvl[l-1].rmx[2*n+1];
        assign amn = g_lvl[l-1].rmn[2*n];
        assign bmn = g_lvl[l-1].rmn[2*n+1];
      end
      fp32_maxmin_unit u_mx (.a_i(amx), .b_i(bmx), .max_o(cmx[n]), .min_o(lo_unused));
      fp32_maxmin_unit u_mn (.a_i(amn), .b_i(bmn), .max_o(hi_unused), .min_o(cmn[n]));
    end

    if (PIPELINE != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rstn) begin
          rmx <= '0;
          rmn <= '0;
          rv  <= 1'b0;
        end else begin
          rmx <= cmx;
          rmn <= cmn;
          rv  <= cv;
        end
      end
    end else begin : g_comb
      assign rmx = cmx;
      assign rmn = cmn;
      assign rv  = cv;
    end
  end

  if (PIPELINE == 0) begin : g_nc
    logic ctl_unused;
    assign ctl_unused = clk ^ rstn;
  end

  assign out_valid = g_lvl[LV-1].rv;
  assign out_max   = g_lvl[LV-1].rmx[0];
  assign out_min   = g_lvl[LV-1].rmn[0];
endmodule

module fp32_minmax_calib_ctrl #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned FINDER_PIPE = 1,
  parameter int unsigned LEN_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               busy,
  output logic               err_len0,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [LANES*32-1:0] s_data,
  output logic               res_valid,
  output logic [31:0]        res_max,
  output logic [31:0]        res_min
);
  localparam int unsigned L    = (FINDER_PIPE != 0) ? $clog2(LANES) : 0;
  localparam int unsigned RW   = $clog2(LANES) + 1;
  localparam int unsigned SR_W = (L == 0) ? 1 : L;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              state_q;
  logic [LEN_W:0]      beats_q, beats_d;
  logic [RW-1:0]       rem_q;
  logic [7:0]          drain_q;
  logic                first_q;
  logic [SR_W-1:0]     vld_sr_q;
  logic [31:0]         acc_max_q, acc_min_q, res_max_q, res_min_q;
  logic                busy_q, s_ready_q, err_len0_q, res_valid_q;
  logic                hs, last_beat, tag;
  logic [LANES*32-1:0] f_in;
  logic [31:0]         f_max, f_min, m_max, m_min;
  logic                f_valid_unused;
  logic [31:0]         acc_max_unused, acc_min_unused;

  assign hs        = s_valid && s_ready_q;
  assign last_beat = (beats_q == (LEN_W+1)'(1));
  assign beats_d   = ((LEN_W+1)'(cfg_len) + (LEN_W+1)'(LANES - 1)) / (LEN_W+1)'(LANES);

  always_comb begin
    f_in = s_data;
    if (last_beat && rem_q != '0) begin
      for (int unsigned i = 1; i < LANES; i++) begin
        if (RW'(i) >= rem_q) f_in[i*32 +: 32] = s_data[31:0];
      end
    end
  end

  fp32_maxmin_finder_pipe #(
    .NUM_INPUTS(LANES),
    .PIPELINE  (FINDER_PIPE)
  ) u_finder (
    .clk      (clk),
    .rstn     (~rst),
    .in_valid (hs),
    .in_data  (f_in),
    .out_valid(f_valid_unused),
    .out_max  (f_max),
    .out_min  (f_min)
  );

  fp32_maxmin_unit u_acc_max (.a_i(acc_max_q), .b_i(f_max), .max_o(m_max), .min_o(acc_max_unused));
  fp32_maxmin_unit u_acc_min (.a_i(acc_min_q), .b_i(f_min), .max_o(acc_min_unused), .min_o(m_min));

  // Finder outputs are tagged by our own shift register so a reset drops in-flight beats.
  if (L == 0) begin : g_tag0
    logic sr_unused;
    assign tag       = hs;
    assign sr_unused = ^vld_sr_q;
  end else begin : g_tagn
    assign tag = vld_sr_q[SR_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beats_q     <= '0;
      rem_q       <= '0;
      drain_q     <= '0;
      first_q     <= 1'b0;
      vld_sr_q    <= '0;
      acc_max_q   <= '0;
      acc_min_q   <= '0;
      res_max_q   <= '0;
      res_min_q   <= '0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      err_len0_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      err_len0_q  <= 1'b0;
      res_valid_q <= 1'b0;
      vld_sr_q[0] <= hs;
      for (int unsigned k = 1; k < SR_W; k++) vld_sr_q[k] <= vld_sr_q[k-1];

      if (tag) begin
        first_q   <= 1'b0;
        acc_max_q <= first_q ? f_max : m_max;
        acc_min_q <= first_q ? f_min : m_min;
      end

      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_len != '0) begin
              beats_q   <= beats_d;
              rem_q     <= RW'(cfg_len % LANES);
              first_q   <= 1'b1;
              busy_q    <= 1'b1;
              s_ready_q <= 1'b1;
              state_q   <= ST_RUN;
            end else begin
              err_len0_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            beats_q <= beats_q - (LEN_W+1)'(1);
            if (last_beat) begin
              s_ready_q <= 1'b0;
              drain_q   <= 8'(L);
              state_q   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            res_valid_q <= 1'b1;
            res_max_q   <= acc_max_q;
            res_min_q   <= acc_min_q;
            state_q     <= ST_DONE;
          end else begin
            drain_q <= drain_q - 8'd1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign s_ready   = s_ready_q;
  assign err_len0  = err_len0_q;
  assign res_valid = res_valid_q;
  assign res_max   = res_max_q;
  assign res_min   = res_min_q;
endmodule

// File: tb/tb_fp32_minmax_calib_ctrl.sv
// Directed bench for fp32_minmax_calib_ctrl: one pipelined (L=2) and one
// combinational-finder (L=0) instance, hand-computed fp32 results.

module tb_fp32_minmax_calib_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cfg_start, s_valid, busy, err_len0, s_ready, res_valid;
  logic [15:0]  cfg_len;
  logic [127:0] s_data;
  logic [31:0]  res_max, res_min;

  logic         cfg_start0, s_valid0, busy0, err_len00, s_ready0, res_valid0;
  logic [15:0]  cfg_len0;
  logic [127:0] s_data0;
  logic [31:0]  res_max0, res_min0;

  int n_checks = 0;
  int n_fail   = 0;

  fp32_minmax_calib_ctrl #(.LANES(4), .FINDER_PIPE(1), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .busy(busy), .err_len0(err_len0), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .res_valid(res_valid), .res_max(res_max), .res_min(res_min)
  );

  fp32_minmax_calib_ctrl #(.LANES(4), .FINDER_PIPE(0), .LEN_W(16)) dut_p0 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start0), .cfg_len(cfg_len0),
    .busy(busy0), .err_len0(err_len00), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_data(s_data0), .res_valid(res_valid0), .res_max(res_max0), .res_min(res_min0)
  );

  localparam logic [31:0] P1 = 32'h3F80_0000, M2 = 32'hC000_0000, P3_5 = 32'h4060_0000;
  localparam logic [31:0] P0_5 = 32'h3F00_0000, P7 = 32'h40E0_0000, M8 = 32'hC100_0000;
  localparam logic [31:0] Z = 32'h0000_0000, P2 = 32'h4000_0000, P3 = 32'h4040_0000;
  localparam logic [31:0] P4 = 32'h4080_0000, M1 = 32'hBF80_0000, P100 = 32'h42C8_0000;
  localparam logic [31:0] M3 = 32'hC040_0000, M5 = 32'hC0A0_0000, P9 = 32'h4110_0000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic start_job(input logic [15:0] len);
    cfg_start = 1'b1;
    cfg_len   = len;
    tick();
    cfg_start = 1'b0;
  endtask

  // Present one beat for one handshake, then idle for gap cycles (optionally poking cfg_start).
  task automatic send(input string tag, input logic [127:0] d, input int gap, input bit poke);
    check({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
    s_data  = '0;
    for (int g = 0; g < gap; g++) begin
      cfg_start = poke;
      cfg_len   = 16'd5;
      tick();
    end
    cfg_start = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int exp_lat);
    int n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_len = '0; s_valid = 1'b0; s_data = '0;
    cfg_start0 = 1'b0; cfg_len0 = '0; s_valid0 = 1'b0; s_data0 = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.s_ready", 32'(s_ready), 32'd0);
    check("rst.res_valid", 32'(res_valid), 32'd0);
    check("rst.res_max", res_max, 32'd0);
    check("rst.busy_p0", 32'(busy0), 32'd0);

    // Test 1: len=8, back-to-back beats; res_valid at T+4 (3 ticks after T+1).
    start_job(16'd8);
    check("t1.busy", 32'(busy), 32'd1);
    send("t1.b0", beat(P1, M2, P3_5, P0_5), 0, 1'b0);
    send("t1.b1", beat(P7, M8, Z, P1), 0, 1'b0);
    check("t1.s_ready_off", 32'(s_ready), 32'd0);
    check("t1.busy_drain", 32'(busy), 32'd1);
    wait_res("t1", 3);
    check("t1.max", res_max, P7);
    check("t1.min", res_min, M8);
    tick();
    check("t1.res_valid_pulse", 32'(res_valid), 32'd0);
    check("t1.busy_idle", 32'(busy), 32'd0);
    check("t1.max_held", res_max, P7);

    // Test 2: len=5, lanes 1..3 of the last beat are padding.
    start_job(16'd5);
    send("t2.b0", beat(P1, P2, P3, P4), 0, 1'b0);
    send("t2.b1", beat(M1, P100, P100, P100), 0, 1'b0);
    wait_res("t2", 3);
    check("t2.max", res_max, P4);
    check("t2.min", res_min, M1);
    tick();

    // Test 3: zero-length job is rejected.
    start_job(16'd0);
    check("t3.err_len0", 32'(err_len0), 32'd1);
    check("t3.busy", 32'(busy), 32'd0);
    check("t3.s_ready", 32'(s_ready), 32'd0);
    tick();
    check("t3.err_pulse", 32'(err_len0), 32'd0);
    check("t3.busy_after", 32'(busy), 32'd0);
    check("t3.no_res", 32'(res_valid), 32'd0);

    // Test 4: gaps between beats and a cfg_start pulse mid-RUN.
    start_job(16'd8);
    send("t4.b0", beat(P1, M2, P3_5, P0_5), 3, 1'b1);
    send("t4.b1", beat(P7, M8, Z, P1), 0, 1'b0);
    wait_res("t4", 3);
    check("t4.max", res_max, P7);
    check("t4.min", res_min, M8);
    tick();

    // Test 5: reset after the first beat drops it; next job sees only its own data.
    start_job(16'd8);
    send("t5.b0", beat(P100, P100, P100, P100), 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.busy", 32'(busy), 32'd0);
    check("t5.s_ready", 32'(s_ready), 32'd0);
    check("t5.err_len0", 32'(err_len0), 32'd0);
    check("t5.res_valid", 32'(res_valid), 32'd0);
    check("t5.res_max", res_max, 32'd0);
    check("t5.res_min", res_min, 32'd0);
    start_job(16'd4);
    send("t5.b1", beat(M3, M3, M3, M3), 0, 1'b0);
    wait_res("t5", 3);
    check("t5.max", res_max, M3);
    check("t5.min", res_min, M3);
    tick();

    // Test 6: combinational finder, len=3, lane 3 ignored; res_valid at T+2.
    begin
      int n = 0;
      cfg_start0 = 1'b1;
      cfg_len0   = 16'd3;
      tick();
      cfg_start0 = 1'b0;
      check("t6.s_ready", 32'(s_ready0), 32'd1);
      s_valid0 = 1'b1;
      s_data0  = beat(P2, M5, P9, P100);
      tick();
      s_valid0 = 1'b0;
      while (res_valid0 !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("t6.res_valid", 32'(res_valid0), 32'd1);
      check("t6.latency", 32'(n), 32'd1);
      check("t6.max", res_max0, P9);
      check("t6.min", res_min0, M5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
